// File: rtl/psum_requant_drain_if.sv
`default_nettype none
// ============================================================================
// Module   : psum_requant_drain_if
// Brief    : Packed-word output bus (valid/ready) of the psum requant drain.
// Revision : 1.0
// ============================================================================
interface psum_requant_drain_if #(
   parameter int OUT_W = 8,
   parameter int PACK  = 4
) ();
   logic                    m_valid;
   logic                    m_ready;
   logic [PACK*OUT_W-1:0]   m_data;
   logic [PACK-1:0]         m_keep;

   modport master (output m_valid, output m_data, output m_keep, input m_ready);
   modport slave  (input m_valid, input m_data, input m_keep, output m_ready);
endinterface
`default_nettype wire

// File: rtl/psum_requant_drain.sv
`default_nettype none
// ============================================================================
// Module   : psum_requant_drain
// Brief    : Requantizes accumulator sums, packs PACK lanes per word, FIFOs out.
// Revision : 1.0
// ============================================================================
module psum_requant_drain #(
   parameter int ACC_W      = 16,
   parameter int OUT_W      = 8,
   parameter int PACK       = 4,
   parameter int FIFO_DEPTH = 4
) (
   input  wire logic                clk,
   input  wire logic                reset,
   input  wire logic                i_acc_valid,
   input  wire logic [ACC_W-1:0]    i_acc_sum,
   input  wire logic [3:0]          i_cfg_shift,
   input  wire logic                i_cfg_relu,
   input  wire logic                i_flush,
   output logic                     o_almost_full,
   output logic                     o_ovf_err,
   psum_requant_drain_if.master     m_if
);
   localparam int SW = ACC_W + 1;
   localparam int LW = (PACK > 1) ? $clog2(PACK) : 1;
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = PW + 1;
   localparam int WW = PACK * OUT_W;
   localparam logic signed [SW-1:0] c_MAX = SW'((1 << (OUT_W - 1)) - 1);
   localparam logic signed [SW-1:0] c_MIN = -c_MAX - SW'(1);

   // ---------------- Stage Q: ReLU, round-half-up shift, saturate ----------
   logic signed [SW-1:0] w_v, w_sum, w_r;
   logic        [SW-1:0] w_rnd;
   logic        [OUT_W-1:0] w_q;
   logic                 r_q_valid;
   logic        [OUT_W-1:0] r_q;

   always_comb begin
      w_v = {i_acc_sum[ACC_W-1], i_acc_sum};
      if (i_cfg_relu && i_acc_sum[ACC_W-1])
         w_v = '0;
      // One extra bit keeps v + half-LSB from wrapping.
      w_rnd = ({{ACC_W{1'b0}}, 1'b1} << i_cfg_shift) >> 1;
      w_sum = w_v + $signed(w_rnd);
      w_r   = w_sum >>> i_cfg_shift;
      if (w_r > c_MAX)
         w_q = c_MAX[OUT_W-1:0];
      else if (w_r < c_MIN)
         w_q = c_MIN[OUT_W-1:0];
      else
         w_q = w_r[OUT_W-1:0];
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_q_valid <= 1'b0;
         r_q       <= '0;
      end else begin
         r_q_valid <= i_acc_valid;
         if (i_acc_valid)
            r_q <= w_q;
      end
   end

   // ---------------- Stage P: lane packer ----------------------------------
   logic [LW-1:0]   r_lane_idx;
   logic [WW-1:0]   r_pack, w_pack_nx;
   logic [PACK-1:0] r_keep, w_keep_nx;
   logic            w_push;

   always_comb begin
      w_pack_nx = r_pack;
      w_keep_nx = r_keep;
      if (r_q_valid) begin
         w_pack_nx[int'(r_lane_idx)*OUT_W +: OUT_W] = r_q;
         w_keep_nx[r_lane_idx] = 1'b1;
      end
      w_push = (r_q_valid && (r_lane_idx == LW'(PACK - 1))) ||
               (i_flush && (|w_keep_nx));
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_lane_idx <= '0;
         r_pack     <= '0;
         r_keep     <= '0;
      end else if (w_push) begin
         r_lane_idx <= '0;
         r_pack     <= '0;
         r_keep     <= '0;
      end else if (r_q_valid) begin
         r_lane_idx <= r_lane_idx + LW'(1);
         r_pack     <= w_pack_nx;
         r_keep     <= w_keep_nx;
      end
   end

   // ---------------- Output FIFO -------------------------------------------
   logic [WW-1:0]   r_mem_data [FIFO_DEPTH];
   logic [PACK-1:0] r_mem_keep [FIFO_DEPTH];
   logic [PW-1:0]   r_wptr, r_rptr;
   logic [CW-1:0]   r_count;
   logic            r_ovf;
   logic            w_mvalid, w_full, w_pop, w_wr;

   always_comb begin
      w_mvalid = (r_count != '0);
      w_full   = (r_count == CW'(FIFO_DEPTH));
      w_pop    = w_mvalid && m_if.m_ready;
      // A full FIFO still takes the word when the head leaves the same cycle.
      w_wr     = w_push && (!w_full || w_pop);
   end

   always_ff @(posedge clk) begin
      if (w_wr) begin
         r_mem_data[r_wptr] <= w_pack_nx;
         r_mem_keep[r_wptr] <= w_keep_nx;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
         r_ovf   <= 1'b0;
      end else begin
         if (w_wr)
            r_wptr <= r_wptr + PW'(1);
         if (w_pop)
            r_rptr <= r_rptr + PW'(1);
         if (w_wr && !w_pop)
            r_count <= r_count + CW'(1);
         else if (!w_wr && w_pop)
            r_count <= r_count - CW'(1);
         if (w_push && !w_wr)
            r_ovf <= 1'b1;
      end
   end

   assign m_if.m_valid  = w_mvalid;
   assign m_if.m_data   = w_mvalid ? r_mem_data[r_rptr] : '0;
   assign m_if.m_keep   = w_mvalid ? r_mem_keep[r_rptr] : '0;
   assign o_almost_full = (r_count >= CW'(FIFO_DEPTH - 1));
   assign o_ovf_err     = r_ovf;
endmodule
`default_nettype wire

// File: tb/tb_psum_requant_drain.sv
`default_nettype none
// ============================================================================
// Module   : tb_psum_requant_drain
// Brief    : Directed self-checking bench for psum_requant_drain.
// Revision : 1.0
// ============================================================================
module tb_psum_requant_drain;
   logic        clk = 1'b0;
   logic        reset;
   logic        acc_valid, cfg_relu, flush;
   logic [15:0] acc_sum;
   logic [3:0]  cfg_shift;
   logic        almost_full, ovf_err;
   int          errors = 0;
   int          checks = 0;

   always #5 clk = ~clk;

   psum_requant_drain_if #(.OUT_W(8), .PACK(4)) m_if ();

   psum_requant_drain #(.ACC_W(16), .OUT_W(8), .PACK(4), .FIFO_DEPTH(4)) dut (
      .clk           (clk),
      .reset         (reset),
      .i_acc_valid   (acc_valid),
      .i_acc_sum     (acc_sum),
      .i_cfg_shift   (cfg_shift),
      .i_cfg_relu    (cfg_relu),
      .i_flush       (flush),
      .o_almost_full (almost_full),
      .o_ovf_err     (ovf_err),
      .m_if          (m_if)
   );

   // Called at a falling edge; presents one sample for the next rising edge.
   task automatic drive(input int s);
      acc_valid = 1'b1;
      acc_sum   = 16'(s);
      @(negedge clk);
      acc_valid = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1; acc_valid = 0; acc_sum = 0; cfg_shift = 0; cfg_relu = 0;
      flush = 0; m_if.m_ready = 0;
      repeat (2) @(negedge clk);
      checks++; if (m_if.m_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b want 0", m_if.m_valid); end
      checks++; if (m_if.m_data !== 32'h0) begin errors++; $display("FAIL rst_data got %h want 0", m_if.m_data); end
      checks++; if (m_if.m_keep !== 4'h0) begin errors++; $display("FAIL rst_keep got %h want 0", m_if.m_keep); end
      checks++; if (almost_full !== 1'b0) begin errors++; $display("FAIL rst_afull got %b want 0", almost_full); end
      checks++; if (ovf_err !== 1'b0) begin errors++; $display("FAIL rst_ovf got %b want 0", ovf_err); end
      reset = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_basic(input logic relu, input logic [31:0] exp);
      cfg_shift = 4'd1; cfg_relu = relu; m_if.m_ready = 1'b1;
      drive(100); drive(200); drive(-5); drive(300);
      checks++; if (m_if.m_valid !== 1'b0) begin errors++; $display("FAIL basic_early relu=%b got %b want 0", relu, m_if.m_valid); end
      @(negedge clk);
      checks++; if (m_if.m_valid !== 1'b1) begin errors++; $display("FAIL basic_valid relu=%b got %b want 1", relu, m_if.m_valid); end
      checks++; if (m_if.m_data !== exp) begin errors++; $display("FAIL basic_data relu=%b got %h want %h", relu, m_if.m_data, exp); end
      checks++; if (m_if.m_keep !== 4'hF) begin errors++; $display("FAIL basic_keep relu=%b got %h want f", relu, m_if.m_keep); end
      @(negedge clk);
      checks++; if (m_if.m_valid !== 1'b0) begin errors++; $display("FAIL basic_popped relu=%b got %b want 0", relu, m_if.m_valid); end
   endtask

   task automatic test_neg_sat();
      cfg_shift = 4'd2; cfg_relu = 1'b0; m_if.m_ready = 1'b1;
      drive(-1000); drive(0); drive(0); drive(0);
      @(negedge clk);
      checks++; if (m_if.m_data !== 32'h0000_0080) begin errors++; $display("FAIL negsat_data got %h want 00000080", m_if.m_data); end
      checks++; if (m_if.m_keep !== 4'hF) begin errors++; $display("FAIL negsat_keep got %h want f", m_if.m_keep); end
      @(negedge clk);
   endtask

   task automatic test_flush();
      cfg_shift = 4'd0; cfg_relu = 1'b0; m_if.m_ready = 1'b1;
      drive(1); drive(2); drive(3);
      flush = 1'b1;               // coincides with the last lane entering the pack
      @(negedge clk);
      flush = 1'b0;
      checks++; if (m_if.m_valid !== 1'b1) begin errors++; $display("FAIL flush_valid got %b want 1", m_if.m_valid); end
      checks++; if (m_if.m_data !== 32'h0003_0201) begin errors++; $display("FAIL flush_data got %h want 00030201", m_if.m_data); end
      checks++; if (m_if.m_keep !== 4'b0111) begin errors++; $display("FAIL flush_keep got %b want 0111", m_if.m_keep); end
      @(negedge clk);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      @(negedge clk);
      checks++; if (m_if.m_valid !== 1'b0) begin errors++; $display("FAIL flush_empty got %b want 0", m_if.m_valid); end
      drive(5);
      @(negedge clk);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      checks++; if (m_if.m_valid !== 1'b1) begin errors++; $display("FAIL flush_idle_valid got %b want 1", m_if.m_valid); end
      checks++; if (m_if.m_data !== 32'h0000_0005) begin errors++; $display("FAIL flush_idle_data got %h want 00000005", m_if.m_data); end
      checks++; if (m_if.m_keep !== 4'b0001) begin errors++; $display("FAIL flush_idle_keep got %b want 0001", m_if.m_keep); end
      @(negedge clk);
   endtask

   task automatic test_overflow();
      logic [31:0] exp;
      cfg_shift = 4'd0; cfg_relu = 1'b0; m_if.m_ready = 1'b0;
      for (int k = 0; k < 5; k++) begin
         for (int l = 0; l < 4; l++) drive(16 * k + l + 1);
         @(negedge clk);
         checks++; if (almost_full !== (k >= 2)) begin errors++; $display("FAIL ovf_afull word=%0d got %b want %b", k, almost_full, (k >= 2)); end
         checks++; if (ovf_err !== (k == 4)) begin errors++; $display("FAIL ovf_err word=%0d got %b want %b", k, ovf_err, (k == 4)); end
      end
      m_if.m_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         for (int l = 0; l < 4; l++) exp[l*8 +: 8] = 8'(16 * k + l + 1);
         checks++; if (m_if.m_valid !== 1'b1 || m_if.m_data !== exp) begin
            errors++; $display("FAIL ovf_drain word=%0d got v=%b %h want v=1 %h", k, m_if.m_valid, m_if.m_data, exp);
         end
         @(negedge clk);
      end
      checks++; if (m_if.m_valid !== 1'b0) begin errors++; $display("FAIL ovf_drained got %b want 0", m_if.m_valid); end
      checks++; if (ovf_err !== 1'b1) begin errors++; $display("FAIL ovf_sticky got %b want 1", ovf_err); end
   endtask

   task automatic test_reset_mid();
      cfg_shift = 4'd0; cfg_relu = 1'b0; m_if.m_ready = 1'b0;
      for (int i = 0; i < 10; i++) drive(i + 1);
      @(negedge clk);
      checks++; if (m_if.m_valid !== 1'b1) begin errors++; $display("FAIL mid_pre_valid got %b want 1", m_if.m_valid); end
      reset = 1'b1;
      #1;
      checks++; if (m_if.m_valid !== 1'b0) begin errors++; $display("FAIL mid_valid got %b want 0", m_if.m_valid); end
      checks++; if (ovf_err !== 1'b0) begin errors++; $display("FAIL mid_ovf got %b want 0", ovf_err); end
      checks++; if (m_if.m_data !== 32'h0) begin errors++; $display("FAIL mid_data got %h want 0", m_if.m_data); end
      @(negedge clk);
      reset = 1'b0;
      drive(8'h0A); drive(8'h0B); drive(8'h0C); drive(8'h0D);
      @(negedge clk);
      checks++; if (m_if.m_valid !== 1'b1) begin errors++; $display("FAIL post_valid got %b want 1", m_if.m_valid); end
      checks++; if (m_if.m_data !== 32'h0D0C_0B0A) begin errors++; $display("FAIL post_data got %h want 0d0c0b0a", m_if.m_data); end
      checks++; if (m_if.m_keep !== 4'hF) begin errors++; $display("FAIL post_keep got %h want f", m_if.m_keep); end
      m_if.m_ready = 1'b1;
      @(negedge clk);
      checks++; if (m_if.m_valid !== 1'b0) begin errors++; $display("FAIL post_popped got %b want 0", m_if.m_valid); end
   endtask

   initial begin
      test_reset();
      test_basic(1'b0, 32'h7FFE_6432);
      test_basic(1'b1, 32'h7F00_6432);
      test_neg_sat();
      test_flush();
      test_overflow();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
`default_nettype wire
